// File: rtl/cmos_frame_window.sv
// Frame gate and crop window for the OV5640 capture path: drops the settling
// frames after reset, gates capture per frame and crops RGB565 pixels to a window.
module cmos_frame_window #(
    parameter int H_START     = 0,
    parameter int V_START     = 0,
    parameter int H_ACTIVE    = 480,
    parameter int V_ACTIVE    = 272,
    parameter int SKIP_FRAMES = 10,
    parameter int CNT_W       = 12
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vsync_i,
    input  logic        de_i,
    input  logic [15:0] pdata_i,
    input  logic        enable_i,
    output logic [15:0] pdata_o,
    output logic        de_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        frame_err_o,
    output logic        skip_done_o
);

    localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [SKIP_W-1:0] SKIP_N = SKIP_W'(SKIP_FRAMES);

    // Window bounds carry one extra bit so START+ACTIVE cannot wrap.
    localparam logic [CNT_W:0] X_LO   = (CNT_W+1)'(H_START);
    localparam logic [CNT_W:0] X_HI   = (CNT_W+1)'(H_START + H_ACTIVE);
    localparam logic [CNT_W:0] X_LAST = (CNT_W+1)'(H_START + H_ACTIVE - 1);
    localparam logic [CNT_W:0] Y_LO   = (CNT_W+1)'(V_START);
    localparam logic [CNT_W:0] Y_HI   = (CNT_W+1)'(V_START + V_ACTIVE);
    localparam logic [CNT_W:0] Y_LAST = (CNT_W+1)'(V_START + V_ACTIVE - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic              vsync_d;
    logic              de_d;
    logic              frame_pass;
    logic              done;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic [SKIP_W-1:0] skip_cnt;

    logic              vs_rise;
    logic              de_v;
    logic [CNT_W:0]    x_w;
    logic [CNT_W:0]    y_w;
    logic              in_win;
    logic              hit;
    logic              at_first;
    logic              at_last;

    always_comb begin
        vs_rise  = vsync_i & ~vsync_d;
        // Pixels during vsync are ignored entirely, including for line counting.
        de_v     = de_i & ~vsync_i;
        x_w      = {1'b0, x};
        y_w      = {1'b0, y};
        in_win   = (x_w >= X_LO) && (x_w < X_HI) && (y_w >= Y_LO) && (y_w < Y_HI);
        hit      = de_v & in_win & frame_pass;
        at_first = (x_w == X_LO) && (y_w == Y_LO);
        at_last  = (x_w == X_LAST) && (y_w == Y_LAST);
    end

    assign skip_done_o = (skip_cnt == SKIP_N);

    // Stage 0: frame bookkeeping and pixel position counters
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b0;
            de_d       <= 1'b0;
            x          <= '0;
            y          <= '0;
            skip_cnt   <= '0;
            frame_pass <= 1'b0;
            done       <= 1'b0;
        end else begin
            vsync_d <= vsync_i;
            de_d    <= de_v;
            if (vs_rise) begin
                if (skip_cnt < SKIP_N) begin
                    skip_cnt   <= skip_cnt + SKIP_W'(1);
                    frame_pass <= 1'b0;
                end else begin
                    frame_pass <= enable_i;
                end
                x    <= '0;
                y    <= '0;
                done <= 1'b0;
            end else begin
                x <= de_v ? sat_inc(x) : '0;
                if (de_d & ~de_v)
                    y <= sat_inc(y);
                if (hit & at_last)
                    done <= 1'b1;
            end
        end
    end

    // Stage 1: registered window outputs, one pclk behind the input pixel
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pdata_o       <= '0;
            de_o          <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            de_o          <= hit;
            frame_start_o <= hit & at_first;
            frame_end_o   <= hit & at_last;
            if (hit)
                pdata_o <= pdata_i;
            if (vs_rise & frame_pass & ~done)
                frame_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmos_frame_window.sv
// Bench for cmos_frame_window: frame-level model driven from stimulus coordinates,
// per-cycle output comparison plus literal pixel expectations.
module tb_cmos_frame_window;

    localparam int HS = 2;
    localparam int VS = 1;
    localparam int HA = 4;
    localparam int VA = 2;
    localparam int SK = 1;

    logic        pclk     = 1'b0;
    logic        rst_n    = 1'b1;
    logic        vsync_i  = 1'b0;
    logic        de_i     = 1'b0;
    logic [15:0] pdata_i  = '0;
    logic        enable_i = 1'b0;
    logic [15:0] pdata_o;
    logic        de_o;
    logic        frame_start_o;
    logic        frame_end_o;
    logic        frame_err_o;
    logic        skip_done_o;

    cmos_frame_window #(
        .H_START(HS), .V_START(VS), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .SKIP_FRAMES(SK), .CNT_W(12)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .vsync_i(vsync_i), .de_i(de_i),
        .pdata_i(pdata_i), .enable_i(enable_i), .pdata_o(pdata_o), .de_o(de_o),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
        .frame_err_o(frame_err_o), .skip_done_o(skip_done_o)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int passes = 0;

    // Frame-level model state
    int  frames_m  = 0;
    bit  pass_m    = 0;
    bit  done_m    = 0;
    bit  err_m     = 0;
    bit  vs_prev_m = 0;

    logic        nxt_de = 0, nxt_start = 0, nxt_end = 0, nxt_err = 0, nxt_skip = 0;
    logic [15:0] nxt_data = '0;
    logic        exp_de = 0, exp_start = 0, exp_end = 0, exp_err = 0, exp_skip = 0;
    logic [15:0] exp_data = '0;

    bit          chk_en = 0;
    int          n_de = 0, n_start = 0, n_end = 0;
    logic [15:0] start_d = '0, end_d = '0;
    logic [15:0] cap[$];

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            exp_de <= 0; exp_start <= 0; exp_end <= 0;
            exp_err <= 0; exp_skip <= 0; exp_data <= '0;
        end else begin
            exp_de <= nxt_de; exp_start <= nxt_start; exp_end <= nxt_end;
            exp_err <= nxt_err; exp_skip <= nxt_skip; exp_data <= nxt_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
    endtask

    initial begin
        forever begin
            @(negedge pclk);
            if (chk_en) begin
                chk("de_o",          32'(de_o),          32'(exp_de));
                chk("pdata_o",       32'(pdata_o),       32'(exp_data));
                chk("frame_start_o", 32'(frame_start_o), 32'(exp_start));
                chk("frame_end_o",   32'(frame_end_o),   32'(exp_end));
                chk("frame_err_o",   32'(frame_err_o),   32'(exp_err));
                chk("skip_done_o",   32'(skip_done_o),   32'(exp_skip));
                if (de_o === 1'b1) begin
                    n_de++;
                    cap.push_back(pdata_o);
                end
                if (frame_start_o === 1'b1) begin n_start++; start_d = pdata_o; end
                if (frame_end_o === 1'b1)   begin n_end++;   end_d   = pdata_o; end
            end
        end
    end

    task automatic clr();
        n_de = 0; n_start = 0; n_end = 0;
        start_d = '0; end_d = '0;
        cap.delete();
    endtask

    // One input cycle: ly/px are the stimulus line and pixel indices.
    task automatic cyc(input bit vs, input bit de, input int ly, input int px);
        bit hit, in_w;
        vsync_i = vs;
        de_i    = de;
        pdata_i = {ly[7:0], px[7:0]};
        if (vs && !vs_prev_m) begin
            if (pass_m && !done_m) err_m = 1;
            if (frames_m < SK) begin
                frames_m++;
                pass_m = 0;
            end else begin
                pass_m = enable_i;
            end
            done_m = 0;
        end
        vs_prev_m = vs;
        in_w = (px >= HS) && (px < HS + HA) && (ly >= VS) && (ly < VS + VA);
        hit  = de && !vs && pass_m && in_w;
        nxt_de    = hit;
        if (hit) nxt_data = pdata_i;
        nxt_start = hit && (px == HS) && (ly == VS);
        nxt_end   = hit && (px == HS + HA - 1) && (ly == VS + VA - 1);
        if (nxt_end) done_m = 1;
        nxt_err   = err_m;
        nxt_skip  = (frames_m >= SK);
        @(posedge pclk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        vsync_i = 1'b0;
        de_i    = 1'b0;
        frames_m = 0; pass_m = 0; done_m = 0; err_m = 0; vs_prev_m = 0;
        nxt_de = 0; nxt_start = 0; nxt_end = 0; nxt_err = 0; nxt_skip = 0; nxt_data = '0;
        #1;
        chk("rst_de_o",          32'(de_o),          32'd0);
        chk("rst_pdata_o",       32'(pdata_o),       32'd0);
        chk("rst_frame_start_o", 32'(frame_start_o), 32'd0);
        chk("rst_frame_end_o",   32'(frame_end_o),   32'd0);
        chk("rst_frame_err_o",   32'(frame_err_o),   32'd0);
        chk("rst_skip_done_o",   32'(skip_done_o),   32'd0);
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
    endtask

    // vsync pulse then nlines lines of 8 pixels with 2-cycle gaps.
    task automatic send_frame(input int nlines, input int en_drop_line,
                              input bit de_at_vs, input int rst_line);
        if (de_at_vs) cyc(0, 1, 4, 0);
        cyc(1, de_at_vs, 4, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int ly = 0; ly < nlines; ly++) begin
            if (ly == rst_line) reset_dut();
            if (ly == en_drop_line) enable_i = 1'b0;
            for (int px = 0; px < 8; px++) cyc(0, 1, ly, px);
            cyc(0, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
    endtask

    logic [15:0] full_win [8] = '{16'h0102, 16'h0103, 16'h0104, 16'h0105,
                                  16'h0202, 16'h0203, 16'h0204, 16'h0205};

    task automatic chk_full(input string tag);
        chk({tag, "_count"}, 32'(n_de), 32'd8);
        for (int i = 0; i < 8; i++)
            chk({tag, "_pix"}, 32'((i < cap.size()) ? cap[i] : 16'hdead), 32'(full_win[i]));
        chk({tag, "_start_n"}, 32'(n_start), 32'd1);
        chk({tag, "_start_d"}, 32'(start_d), 32'h0102);
        chk({tag, "_end_n"},   32'(n_end),   32'd1);
        chk({tag, "_end_d"},   32'(end_d),   32'h0205);
    endtask

    initial begin
        #1;
        reset_dut();
        chk_en = 1;

        // Pixels before the first vsync never reach the output
        clr();
        for (int px = 0; px < 8; px++) cyc(0, 1, 1, px);
        cyc(0, 0, 0, 0);
        chk("pre_vs_count", 32'(n_de), 32'd0);

        // Frame 0: settling frame is dropped
        enable_i = 1'b1;
        clr();
        send_frame(4, -1, 0, -1);
        chk("f0_count",     32'(n_de),        32'd0);
        chk("f0_pulses",    32'(n_start + n_end), 32'd0);
        chk("f0_skip_done", 32'(skip_done_o), 32'd1);

        // Frame 1: passed, enable dropped mid-frame
        clr();
        send_frame(4, 2, 0, -1);
        chk_full("f1");
        chk("f1_err", 32'(frame_err_o), 32'd0);

        // Frame 2: gated off by the dropped enable
        clr();
        send_frame(4, -1, 0, -1);
        chk("f2_count", 32'(n_de), 32'd0);

        // Frame 3: short frame, only two lines
        enable_i = 1'b1;
        clr();
        send_frame(2, -1, 0, -1);
        chk("f3_count", 32'(n_de), 32'd4);
        chk("f3_first", 32'((cap.size() > 0) ? cap[0] : 16'hdead), 32'h0102);
        chk("f3_last",  32'((cap.size() > 3) ? cap[3] : 16'hdead), 32'h0105);
        chk("f3_end_n", 32'(n_end), 32'd0);
        chk("f3_err",   32'(frame_err_o), 32'd0);

        // Frame 4: its vsync flags the short frame
        clr();
        send_frame(4, -1, 0, -1);
        chk_full("f4");
        chk("f4_err", 32'(frame_err_o), 32'd1);

        // Frame 5: pixel coincident with the vsync rise is dropped
        clr();
        send_frame(4, -1, 1, -1);
        chk_full("f5");
        chk("f5_err_sticky", 32'(frame_err_o), 32'd1);

        // Frame 6: reset mid-frame
        clr();
        send_frame(4, -1, 0, 2);
        chk("f6_skip_done", 32'(skip_done_o), 32'd0);
        chk("f6_err",       32'(frame_err_o), 32'd0);

        // Frame 7: skipped again after reset
        clr();
        send_frame(4, -1, 0, -1);
        chk("f7_count",     32'(n_de),        32'd0);
        chk("f7_skip_done", 32'(skip_done_o), 32'd1);

        // Frame 8: passes again
        clr();
        send_frame(4, -1, 0, -1);
        chk_full("f8");
        chk("f8_err", 32'(frame_err_o), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
